// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN at compile time to insert the parity bit between data and stop.
module serial_tx #(
   parameter int DIV   = 4,
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD,
   output logic             TXD,
   output logic             BUSY,
   output logic             DONE
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [7:0]    CNT_RELOAD = 8'(DIV - 1);
   localparam logic [IW-1:0] LAST_BIT   = IW'(WIDTH - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
   localparam logic [2:0] PAR   = 3'd3;
`endif
   localparam logic [2:0] STOP  = 3'd4;

`ifdef SERIAL_TX_PARITY_EN
   function automatic logic even_parity(input logic [WIDTH-1:0] data);
      return ^data;
   endfunction
`endif

   logic [2:0]       state_r, state_s;
   logic [7:0]       cnt_r, cnt_s;
   logic [IW-1:0]    bit_idx_r, bit_idx_s;
   logic [WIDTH-1:0] shift_r, shift_s;
   logic             txd_r, txd_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             bit_end_s;
`ifdef SERIAL_TX_PARITY_EN
   logic             par_r, par_s;
`endif

   assign bit_end_s = (cnt_r == 8'd0);

   // Next-state logic; outputs are computed here and registered so TXD/BUSY/DONE never glitch.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      bit_idx_s = bit_idx_r;
      shift_s   = shift_r;
      txd_s     = txd_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_s     = par_r;
`endif
      case (state_r)
         IDLE: begin
            if (LOAD) begin
               state_s   = START;
               cnt_s     = CNT_RELOAD;
               bit_idx_s = {IW{1'b0}};
               shift_s   = D;
               txd_s     = 1'b0;
               busy_s    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
               par_s     = even_parity(D);
`endif
            end else begin
               txd_s  = 1'b1;
               busy_s = 1'b0;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_s = DATA;
               cnt_s   = CNT_RELOAD;
               txd_s   = shift_r[0];
               shift_s = shift_r >> 1;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               cnt_s = CNT_RELOAD;
               if (bit_idx_r == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_s = PAR;
                  txd_s   = par_r;
`else
                  state_s = STOP;
                  txd_s   = 1'b1;
`endif
               end else begin
                  bit_idx_s = bit_idx_r + IW'(1);
                  txd_s     = shift_r[0];
                  shift_s   = shift_r >> 1;
               end
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PAR: begin
            if (bit_end_s) begin
               state_s = STOP;
               cnt_s   = CNT_RELOAD;
               txd_s   = 1'b1;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
`endif
         STOP: begin
            if (bit_end_s) begin
               state_s   = IDLE;
               cnt_s     = 8'd0;
               bit_idx_s = {IW{1'b0}};
               shift_s   = {WIDTH{1'b0}};
               txd_s     = 1'b1;
               busy_s    = 1'b0;
               done_s    = 1'b1;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         default: begin
            // Unreachable encodings recover to a clean idle line.
            state_s   = IDLE;
            cnt_s     = 8'd0;
            bit_idx_s = {IW{1'b0}};
            shift_s   = {WIDTH{1'b0}};
            txd_s     = 1'b1;
            busy_s    = 1'b0;
            done_s    = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous clear to an idle-high line.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_r   <= IDLE;
         cnt_r     <= 8'd0;
         bit_idx_r <= {IW{1'b0}};
         shift_r   <= {WIDTH{1'b0}};
         txd_r     <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_r     <= 1'b0;
`endif
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         bit_idx_r <= bit_idx_s;
         shift_r   <= shift_s;
         txd_r     <= txd_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
`ifdef SERIAL_TX_PARITY_EN
         par_r     <= par_s;
`endif
      end
   end

   assign TXD  = txd_r;
   assign BUSY = busy_r;
   assign DONE = done_r;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus queues expected words, per-instance monitors
// rebuild each frame from TXD and check it when DONE pulses.
module tb_serial_tx;

   localparam int DIV0 = 4;
   localparam int DIV1 = 1;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       CLK;
   logic       CLR;
   logic [7:0] d0, d1;
   logic       load0, load1;
   logic       txd0, busy0, done0;
   logic       txd1, busy1, done1;

   int checks = 0;
   int errors = 0;

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   serial_tx #(.DIV(DIV0), .WIDTH(8)) u_dut0 (
      .CLK(CLK), .CLR(CLR), .D(d0), .LOAD(load0), .TXD(txd0), .BUSY(busy0), .DONE(done0)
   );

   serial_tx #(.DIV(DIV1), .WIDTH(8)) u_dut1 (
      .CLK(CLK), .CLR(CLR), .D(d1), .LOAD(load1), .TXD(txd1), .BUSY(busy1), .DONE(done1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference line level at sample i (0-based from the first busy cycle).
   function automatic logic exp_level(input logic [7:0] data, input int i, input int div);
      int b;
      b = i / div;
      if (b == 0) return 1'b0;
      if (b <= 8) return data[b-1];
`ifdef SERIAL_TX_PARITY_EN
      if (b == 9) return ^data;
`endif
      return 1'b1;
   endfunction

   // Monitor for the DIV=4 instance.
   initial begin
      logic       buf0 [0:511];
      int         n0;
      logic       prev_done;
      logic [7:0] exp, dec;
      int         mism;
      n0 = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge CLK);
         if (done0) begin
            check("dut0_done_width", {31'd0, prev_done}, 32'd0);
            check("dut0_busy_at_done", {31'd0, busy0}, 32'd0);
            check("dut0_done_expected", (q0.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (q0.size() != 0) begin
               exp = q0.pop_front();
               check("dut0_frame_len", n0, NB * DIV0);
               mism = 0;
               for (int i = 0; i < n0 && i < 512; i++)
                  if (buf0[i] !== exp_level(exp, i, DIV0)) mism++;
               check("dut0_waveform", mism, 0);
               for (int b = 0; b < 8; b++) dec[b] = buf0[(b + 1) * DIV0 + DIV0 / 2];
               check("dut0_data", {24'd0, dec}, {24'd0, exp});
            end
            n0 = 0;
         end else if (!busy0) begin
            n0 = 0;
         end else begin
            if (n0 < 512) buf0[n0] = txd0;
            n0++;
         end
         prev_done = done0;
      end
   end

   // Monitor for the DIV=1 instance, also checking the DONE spacing of back-to-back frames.
   initial begin
      logic       buf1 [0:511];
      int         n1, ncyc, last_done;
      logic [7:0] exp, dec;
      int         mism;
      n1 = 0;
      ncyc = 0;
      last_done = -1;
      forever begin
         @(negedge CLK);
         ncyc++;
         if (done1) begin
            check("dut1_done_expected", (q1.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (last_done >= 0) check("dut1_done_gap", ncyc - last_done, NB + 1);
            last_done = ncyc;
            if (q1.size() != 0) begin
               exp = q1.pop_front();
               check("dut1_frame_len", n1, NB * DIV1);
               mism = 0;
               for (int i = 0; i < n1 && i < 512; i++)
                  if (buf1[i] !== exp_level(exp, i, DIV1)) mism++;
               check("dut1_waveform", mism, 0);
               for (int b = 0; b < 8; b++) dec[b] = buf1[b + 1];
               check("dut1_data", {24'd0, dec}, {24'd0, exp});
            end
            n1 = 0;
         end else if (!busy1) begin
            n1 = 0;
         end else begin
            if (n1 < 512) buf1[n1] = txd1;
            n1++;
         end
      end
   end

   task automatic send0(input logic [7:0] d, input bit push);
      @(posedge CLK);
      #1;
      d0 = d;
      load0 = 1'b1;
      if (push) q0.push_back(d);
      @(posedge CLK);
      #1;
      load0 = 1'b0;
      check("dut0_start_txd", {31'd0, txd0}, 32'd0);
      check("dut0_start_busy", {31'd0, busy0}, 32'd1);
   endtask

   task automatic wait_done0(input int limit);
      bit found;
      found = 1'b0;
      for (int k = 0; k < limit && !found; k++) begin
         @(negedge CLK);
         if (done0) found = 1'b1;
      end
      check("dut0_done_seen", {31'd0, found}, 32'd1);
   endtask

   initial begin
      int frames;
      CLR = 1'b0;
      d0 = 8'h00;
      d1 = 8'h00;
      load0 = 1'b0;
      load1 = 1'b0;

      // Reset state, while held and after release.
      repeat (3) @(negedge CLK);
      check("reset_txd", {31'd0, txd0}, 32'd1);
      check("reset_busy", {31'd0, busy0}, 32'd0);
      check("reset_done", {31'd0, done0}, 32'd0);
      @(posedge CLK);
      #1;
      CLR = 1'b1;
      @(negedge CLK);
      check("idle_txd", {31'd0, txd0}, 32'd1);
      check("idle_busy1", {31'd0, busy1}, 32'd0);

      // Basic frame.
      send0(8'hA5, 1'b1);
      wait_done0(100);

      // Second LOAD during a frame is ignored.
      send0(8'h3C, 1'b1);
      repeat (9) @(posedge CLK);
      #1;
      d0 = 8'hFF;
      load0 = 1'b1;
      @(posedge CLK);
      #1;
      load0 = 1'b0;
      d0 = 8'h00;
      check("dut0_busy_mid", {31'd0, busy0}, 32'd1);
      wait_done0(100);

      // Abort mid-frame with CLR between clock edges.
      send0(8'hC3, 1'b0);
      repeat (16) @(posedge CLK);
      #3;
      CLR = 1'b0;
      #1;
      check("abort_txd", {31'd0, txd0}, 32'd1);
      check("abort_busy", {31'd0, busy0}, 32'd0);
      check("abort_done", {31'd0, done0}, 32'd0);
      d0 = 8'h5A;
      load0 = 1'b1;
      repeat (2) @(negedge CLK);
      check("reset_load_ignored", {31'd0, busy0}, 32'd0);
      @(posedge CLK);
      #1;
      q0.push_back(8'h5A);
      CLR = 1'b1;
      @(posedge CLK);
      #1;
      load0 = 1'b0;
      check("first_accept_txd", {31'd0, txd0}, 32'd0);
      check("first_accept_busy", {31'd0, busy0}, 32'd1);
      wait_done0(100);

      // Extreme data patterns.
      send0(8'h00, 1'b1);
      wait_done0(100);
      send0(8'hFF, 1'b1);
      wait_done0(100);

      // DIV=1, LOAD held high: back-to-back frames.
      @(posedge CLK);
      #1;
      d1 = 8'h81;
      load1 = 1'b1;
      for (int i = 0; i < 3; i++) q1.push_back(8'h81);
      frames = 0;
      for (int k = 0; k < 200 && frames < 3; k++) begin
         @(negedge CLK);
         if (done1) frames++;
      end
      load1 = 1'b0;
      check("dut1_frames", frames, 3);

      repeat (20) @(negedge CLK);
      check("dut0_queue_empty", q0.size(), 0);
      check("dut1_queue_empty", q1.size(), 0);
      check("dut1_idle_after", {31'd0, busy1}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
